// File: rtl/dmem_ctrl_if.sv
// SRAM bus between the data-memory controller and an asynchronous SRAM.
// The controller drives address, data, byte lanes and active-low strobes;
// the SRAM returns read data.
interface dmem_ctrl_if;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [3:0]  sram_be_n_o;

    modport master (
        output sram_addr_o,
        output sram_wdata_o,
        output sram_ce_n_o,
        output sram_oe_n_o,
        output sram_we_n_o,
        output sram_be_n_o,
        input  sram_rdata_i
    );

    modport slave (
        input  sram_addr_o,
        input  sram_wdata_o,
        input  sram_ce_n_o,
        input  sram_oe_n_o,
        input  sram_we_n_o,
        input  sram_be_n_o,
        output sram_rdata_i
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory stage controller: turns execute-stage load/store ops into a
// fixed-length SRAM access (WAIT_CYCLES clocks) while holding the pipeline,
// then hands the load result (or the untouched ALU result) to write-back.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned LW/SW
// with a one-cycle align_err_o pulse instead of accessing the SRAM.
module dmem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  waddr_i,
    input  logic        we_i,
    output logic [31:0] wdata_o,
    output logic [4:0]  waddr_o,
    output logic        we_o,
    output logic        stall_req_o,
    output logic        align_err_o,
    dmem_ctrl_if.master sram
);

    localparam logic [7:0] MEM_NOP = 8'h00;
    localparam logic [7:0] MEM_LB  = 8'h20;
    localparam logic [7:0] MEM_LW  = 8'h23;
    localparam logic [7:0] MEM_SB  = 8'h28;
    localparam logic [7:0] MEM_SW  = 8'h2B;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  op_q;
    logic [21:0] addr_q;
    logic [31:0] data_q;
    logic [4:0]  waddr_q;
    logic        we_q;
    logic [31:0] rdata_q;

    logic        req_valid;
    logic        req_word;
    logic        misaligned;
    logic        latch_en;
    logic        capture_en;
    logic        load_q;
    logic [7:0]  load_byte;
    logic [31:0] load_result;
    logic        addr_hi_unused;

    assign addr_hi_unused = ^mem_addr_i[31:22];

    // Decode the incoming op; NOP and unknown codes are plain ALU results.
    always_comb begin
        req_valid = 1'b0;
        req_word  = 1'b0;
        case (mem_op_i)
            MEM_LB, MEM_SB: req_valid = 1'b1;
            MEM_LW, MEM_SW: begin
                req_valid = 1'b1;
                req_word  = 1'b1;
            end
            MEM_NOP: req_valid = 1'b0;
            default: req_valid = 1'b0;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = req_word && (mem_addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign load_q = (op_q == MEM_LB) || (op_q == MEM_LW);

    // Pick the addressed byte lane of the captured word and build the result.
    always_comb begin
        load_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: load_byte = rdata_q[7:0];
            2'd1: load_byte = rdata_q[15:8];
            2'd2: load_byte = rdata_q[23:16];
            2'd3: load_byte = rdata_q[31:24];
            default: load_byte = 8'h00;
        endcase
        if (op_q == MEM_LB) begin
            load_result = {{24{load_byte[7]}}, load_byte};
        end else begin
            load_result = rdata_q;
        end
    end

    // State register, access counter and the request/read-data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= MEM_NOP;
            addr_q  <= 22'd0;
            data_q  <= 32'd0;
            waddr_q <= 5'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                op_q    <= mem_op_i;
                addr_q  <= mem_addr_i[21:0];
                data_q  <= mem_data_i;
                waddr_q <= waddr_i;
                we_q    <= we_i;
            end
            if (capture_en) begin
                rdata_q <= sram.sram_rdata_i;
            end
        end
    end

    // Next state: accept in IDLE, count WAIT_CYCLES access clocks, one DONE clock.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !misaligned) begin
                    state_d  = ACCESS;
                    cnt_d    = 4'd1;
                    latch_en = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q >= LAST_CNT) begin
                    state_d    = DONE;
                    cnt_d      = 4'd0;
                    capture_en = load_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs: pipeline hand-off and SRAM strobes; reset forces everything quiet.
    always_comb begin
        wdata_o           = wdata_i;
        waddr_o           = waddr_i;
        we_o              = we_i;
        stall_req_o       = 1'b0;
        align_err_o       = 1'b0;
        sram.sram_addr_o  = mem_addr_i[21:2];
        sram.sram_wdata_o = 32'd0;
        sram.sram_ce_n_o  = 1'b1;
        sram.sram_oe_n_o  = 1'b1;
        sram.sram_we_n_o  = 1'b1;
        sram.sram_be_n_o  = 4'b1111;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        align_err_o = 1'b1;
                        if (mem_op_i == MEM_LW) begin
                            we_o = 1'b0;
                        end
                    end else begin
                        stall_req_o = 1'b1;
                        we_o        = 1'b0;
                    end
                end
            end
            ACCESS: begin
                stall_req_o      = 1'b1;
                we_o             = 1'b0;
                sram.sram_addr_o = addr_q[21:2];
                sram.sram_ce_n_o = 1'b0;
                if (load_q) begin
                    sram.sram_oe_n_o = 1'b0;
                    sram.sram_be_n_o = 4'b0000;
                end else if (op_q == MEM_SB) begin
                    sram.sram_we_n_o  = 1'b0;
                    sram.sram_wdata_o = {4{data_q[7:0]}};
                    sram.sram_be_n_o  = ~(4'b0001 << addr_q[1:0]);
                end else begin
                    sram.sram_we_n_o  = 1'b0;
                    sram.sram_wdata_o = data_q;
                    sram.sram_be_n_o  = 4'b0000;
                end
            end
            DONE: begin
                if (load_q) begin
                    wdata_o = load_result;
                    waddr_o = waddr_q;
                    we_o    = we_q;
                end
            end
            default: begin
                stall_req_o = 1'b0;
            end
        endcase
        if (rst) begin
            wdata_o           = 32'd0;
            waddr_o           = 5'd0;
            we_o              = 1'b0;
            stall_req_o       = 1'b0;
            align_err_o       = 1'b0;
            sram.sram_addr_o  = 20'd0;
            sram.sram_wdata_o = 32'd0;
            sram.sram_ce_n_o  = 1'b1;
            sram.sram_oe_n_o  = 1'b1;
            sram.sram_we_n_o  = 1'b1;
            sram.sram_be_n_o  = 4'b1111;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: scripted loads/stores against a
// bench-driven SRAM read bus, with expected write-back results queued at
// issue time and compared when the controller reaches its result cycle.
module tb_dmem_ctrl;
    localparam logic [7:0] MEM_NOP = 8'h00;
    localparam logic [7:0] MEM_LB  = 8'h20;
    localparam logic [7:0] MEM_LW  = 8'h23;
    localparam logic [7:0] MEM_SB  = 8'h28;
    localparam logic [7:0] MEM_SW  = 8'h2B;
    localparam int W = 2;

    typedef struct {
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        we;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_data_i, wdata_i;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic [31:0] wdata_o;
    logic [4:0]  waddr_o;
    logic        we_o, stall_req_o, align_err_o;
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    wb_t         exp_q[$];

    dmem_ctrl_if bus ();

    dmem_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .wdata_i     (wdata_i),
        .waddr_i     (waddr_i),
        .we_i        (we_i),
        .wdata_o     (wdata_o),
        .waddr_o     (waddr_o),
        .we_o        (we_o),
        .stall_req_o (stall_req_o),
        .align_err_o (align_err_o),
        .sram        (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // Issues a load, checks every access cycle, then compares the queued result.
    task automatic do_load(input logic [7:0] op, input logic [31:0] addr, input logic [4:0] wa,
                           input logic [31:0] rdata, input logic [31:0] exp_res,
                           input logic [19:0] exp_word, output int issue_cyc);
        wb_t e;
        int  stalls;
        @(negedge clk);
        mem_op_i = op; mem_addr_i = addr; mem_data_i = 32'h0;
        wdata_i = 32'h5555_5555; waddr_i = wa; we_i = 1'b1;
        bus.sram_rdata_i = rdata;
        issue_cyc = cyc;
        e.wdata = exp_res; e.waddr = wa; e.we = 1'b1;
        exp_q.push_back(e);
        #1;
        total_cnt++;
        if (stall_req_o !== 1'b1 || align_err_o !== 1'b0)
            $display("[TB] FAIL load_issue stall=%b align=%b want 1/0", stall_req_o, align_err_o);
        else pass_cnt++;
        stalls = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!stall_req_o) break;
            stalls++;
            total_cnt++;
            if (bus.sram_ce_n_o !== 1'b0 || bus.sram_oe_n_o !== 1'b0 || bus.sram_we_n_o !== 1'b1 ||
                bus.sram_be_n_o !== 4'b0000 || bus.sram_addr_o !== exp_word)
                $display("[TB] FAIL load_access ce=%b oe=%b we=%b be=%b addr=%h want 0/0/1/0000/%h",
                         bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o, bus.sram_be_n_o,
                         bus.sram_addr_o, exp_word);
            else pass_cnt++;
        end
        total_cnt++;
        if (stalls !== W + 1) $display("[TB] FAIL load_stall_cycles got %0d want %0d", stalls, W + 1);
        else pass_cnt++;
        total_cnt++;
        if (bus.sram_ce_n_o !== 1'b1 || bus.sram_oe_n_o !== 1'b1)
            $display("[TB] FAIL load_done_strobes ce=%b oe=%b want 1/1", bus.sram_ce_n_o, bus.sram_oe_n_o);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL load_result scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (wdata_o !== e.wdata || waddr_o !== e.waddr || we_o !== e.we)
                $display("[TB] FAIL load_result got %h/%0d/%b want %h/%0d/%b",
                         wdata_o, waddr_o, we_o, e.wdata, e.waddr, e.we);
            else pass_cnt++;
        end
    endtask

    // Issues a store, checks lanes/data/strobes each access cycle and DONE passthrough.
    task automatic do_store(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_wd, input logic [3:0] exp_be,
                            input logic [19:0] exp_word);
        wb_t e;
        int  stalls;
        @(negedge clk);
        mem_op_i = op; mem_addr_i = addr; mem_data_i = data;
        wdata_i = 32'h1234_5678; waddr_i = 5'd9; we_i = 1'b0;
        e.wdata = 32'h1234_5678; e.waddr = 5'd9; e.we = 1'b0;
        exp_q.push_back(e);
        #1;
        total_cnt++;
        if (stall_req_o !== 1'b1 || align_err_o !== 1'b0)
            $display("[TB] FAIL store_issue stall=%b align=%b want 1/0", stall_req_o, align_err_o);
        else pass_cnt++;
        stalls = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!stall_req_o) break;
            stalls++;
            total_cnt++;
            if (bus.sram_ce_n_o !== 1'b0 || bus.sram_oe_n_o !== 1'b1 || bus.sram_we_n_o !== 1'b0 ||
                bus.sram_be_n_o !== exp_be || bus.sram_wdata_o !== exp_wd || bus.sram_addr_o !== exp_word)
                $display("[TB] FAIL store_access ce=%b oe=%b we=%b be=%b wd=%h addr=%h want 0/1/0/%b/%h/%h",
                         bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o, bus.sram_be_n_o,
                         bus.sram_wdata_o, bus.sram_addr_o, exp_be, exp_wd, exp_word);
            else pass_cnt++;
        end
        total_cnt++;
        if (stalls !== W + 1) $display("[TB] FAIL store_stall_cycles got %0d want %0d", stalls, W + 1);
        else pass_cnt++;
        total_cnt++;
        if (bus.sram_we_n_o !== 1'b1 || bus.sram_wdata_o !== 32'h0 || bus.sram_be_n_o !== 4'b1111)
            $display("[TB] FAIL store_done_strobes we=%b wd=%h be=%b want 1/0/1111",
                     bus.sram_we_n_o, bus.sram_wdata_o, bus.sram_be_n_o);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL store_passthru scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (wdata_o !== e.wdata || waddr_o !== e.waddr || we_o !== e.we)
                $display("[TB] FAIL store_passthru got %h/%0d/%b want %h/%0d/%b",
                         wdata_o, waddr_o, we_o, e.wdata, e.waddr, e.we);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_op_i = MEM_LW; mem_addr_i = 32'hFFFF_FFFF; mem_data_i = 32'hFFFF_FFFF;
        wdata_i = 32'hFFFF_FFFF; waddr_i = 5'd31; we_i = 1'b1; bus.sram_rdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total_cnt++;
            if (wdata_o !== 32'h0 || waddr_o !== 5'd0 || we_o !== 1'b0 || stall_req_o !== 1'b0 ||
                align_err_o !== 1'b0 || bus.sram_addr_o !== 20'h0 || bus.sram_wdata_o !== 32'h0 ||
                bus.sram_be_n_o !== 4'b1111 || bus.sram_ce_n_o !== 1'b1 ||
                bus.sram_oe_n_o !== 1'b1 || bus.sram_we_n_o !== 1'b1)
                $display("[TB] FAIL reset_outputs wd=%h wa=%0d we=%b st=%b ae=%b addr=%h be=%b ce=%b want all idle",
                         wdata_o, waddr_o, we_o, stall_req_o, align_err_o, bus.sram_addr_o,
                         bus.sram_be_n_o, bus.sram_ce_n_o);
            else pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b0; mem_op_i = MEM_NOP;
    endtask

    task automatic test_passthrough();
        logic [7:0] ops[2] = '{MEM_NOP, 8'hFF};
        foreach (ops[i]) begin
            @(negedge clk);
            mem_op_i = ops[i]; mem_addr_i = 32'h40; wdata_i = 32'h7 + i; waddr_i = 5'd3; we_i = 1'b1;
            #1;
            total_cnt++;
            if (wdata_o !== 32'h7 + i || waddr_o !== 5'd3 || we_o !== 1'b1 || stall_req_o !== 1'b0 ||
                bus.sram_ce_n_o !== 1'b1)
                $display("[TB] FAIL passthru op=%h got %h/%0d/%b st=%b ce=%b want %h/3/1 st=0 ce=1",
                         ops[i], wdata_o, waddr_o, we_o, stall_req_o, bus.sram_ce_n_o, 32'h7 + i);
            else pass_cnt++;
        end
    endtask

    task automatic test_loads();
        int c;
        do_load(MEM_LW, 32'h0000_0010, 5'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 20'h00004, c);
        do_load(MEM_LB, 32'h0000_0013, 5'd5, 32'h8012_3456, 32'hFFFF_FF80, 20'h00004, c);
        do_load(MEM_LB, 32'h0000_0011, 5'd6, 32'h8012_3456, 32'h0000_0034, 20'h00004, c);
        do_load(MEM_LB, 32'h0000_0020, 5'd7, 32'h8012_3456, 32'h0000_0056, 20'h00008, c);
    endtask

    task automatic test_stores();
        do_store(MEM_SB, 32'h0000_0002, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1011, 20'h00000);
        do_store(MEM_SB, 32'h0000_0107, 32'h0000_003C, 32'h3C3C_3C3C, 4'b0111, 20'h00041);
        do_store(MEM_SW, 32'h0000_0008, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b0000, 20'h00002);
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        do_load(MEM_LW, 32'h0000_0100, 5'd10, 32'h1111_2222, 32'h1111_2222, 20'h00040, c1);
        do_load(MEM_LW, 32'h0000_0104, 5'd11, 32'h3333_4444, 32'h3333_4444, 20'h00041, c2);
        total_cnt++;
        if (c2 - c1 !== W + 2) $display("[TB] FAIL back_to_back spacing got %0d want %0d", c2 - c1, W + 2);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int c;
        @(negedge clk);
        mem_op_i = MEM_SW; mem_addr_i = 32'h4; mem_data_i = 32'hCAFE_F00D; we_i = 1'b0;
        @(negedge clk); #1;
        total_cnt++;
        if (bus.sram_we_n_o !== 1'b0) $display("[TB] FAIL abort_first_access we_n=%b want 0", bus.sram_we_n_o);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.sram_ce_n_o !== 1'b1 || bus.sram_we_n_o !== 1'b1 || stall_req_o !== 1'b0)
            $display("[TB] FAIL abort_during_reset ce=%b we=%b st=%b want 1/1/0",
                     bus.sram_ce_n_o, bus.sram_we_n_o, stall_req_o);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; mem_op_i = MEM_NOP; wdata_i = 32'h99; waddr_i = 5'd2; we_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (bus.sram_ce_n_o !== 1'b1 || bus.sram_we_n_o !== 1'b1 || stall_req_o !== 1'b0 ||
                wdata_o !== 32'h99 || we_o !== 1'b1)
                $display("[TB] FAIL abort_after ce=%b we_n=%b st=%b wd=%h want 1/1/0/00000099",
                         bus.sram_ce_n_o, bus.sram_we_n_o, stall_req_o, wdata_o);
            else pass_cnt++;
            @(negedge clk);
        end
        do_load(MEM_LW, 32'h0000_0004, 5'd1, 32'h0BAD_F00D, 32'h0BAD_F00D, 20'h00001, c);
    endtask

    task automatic test_alignment();
`ifdef DMEM_ALIGN_CHECK_EN
        @(negedge clk);
        mem_op_i = MEM_SW; mem_addr_i = 32'h6; mem_data_i = 32'h1122_3344;
        wdata_i = 32'h1; waddr_i = 5'd1; we_i = 1'b0;
        #1;
        total_cnt++;
        if (align_err_o !== 1'b1 || stall_req_o !== 1'b0 || bus.sram_ce_n_o !== 1'b1)
            $display("[TB] FAIL align_sw ae=%b st=%b ce=%b want 1/0/1", align_err_o, stall_req_o, bus.sram_ce_n_o);
        else pass_cnt++;
        @(negedge clk);
        mem_op_i = MEM_LW; mem_addr_i = 32'h5; wdata_i = 32'h2; waddr_i = 5'd8; we_i = 1'b1;
        #1;
        total_cnt++;
        if (align_err_o !== 1'b1 || we_o !== 1'b0 || stall_req_o !== 1'b0 || bus.sram_ce_n_o !== 1'b1)
            $display("[TB] FAIL align_lw ae=%b we=%b st=%b ce=%b want 1/0/0/1",
                     align_err_o, we_o, stall_req_o, bus.sram_ce_n_o);
        else pass_cnt++;
        @(negedge clk);
        mem_op_i = MEM_NOP;
        #1;
        total_cnt++;
        if (align_err_o !== 1'b0 || bus.sram_ce_n_o !== 1'b1)
            $display("[TB] FAIL align_clear ae=%b ce=%b want 0/1", align_err_o, bus.sram_ce_n_o);
        else pass_cnt++;
`else
        do_store(MEM_SW, 32'h0000_0006, 32'h1122_3344, 32'h1122_3344, 4'b0000, 20'h00001);
`endif
    endtask

    initial begin
        $display("[TB] starting dmem_ctrl bench, WAIT_CYCLES=%0d", W);
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_back_to_back();
        test_reset_abort();
        test_alignment();
        total_cnt++;
        if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain left %0d want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
